// File: rtl/pc_sequencer.sv
// Fetch PC sequencer with taken-branch redirect and a wrong-path kill shadow
// that covers the instructions already in flight behind a resolved branch.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        wbValid_i,
    input  logic        branch_i,
    input  logic        aluZero_i,
    input  logic        condZero_i,
    input  logic [31:0] pcBranch_i,
    output logic [31:0] pc_o,
    output logic        redirect_o,
    output logic        kill_o,
    output logic [31:0] takenCnt_o,
    output logic        misalign_o
);

    typedef enum logic {
        RUN    = 1'b0,
        SHADOW = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       taken;
    logic       accept;

    always_comb begin
        taken      = wbValid_i & branch_i & ~(aluZero_i ^ condZero_i);
        accept     = taken & ~stall_i & (state == RUN);
        redirect_o = accept;
        kill_o     = (state == SHADOW);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RUN;
            cnt        <= '0;
            pc_o       <= RESET_PC;
            takenCnt_o <= '0;
            misalign_o <= 1'b0;
        end else if (!stall_i) begin
            case (state)
                RUN: begin
                    if (accept) begin
                        pc_o       <= {pcBranch_i[31:2], 2'b00};
                        cnt        <= 4'(FLUSH_CYCLES);
                        state      <= SHADOW;
                        takenCnt_o <= takenCnt_o + 32'd1;
                        if (pcBranch_i[1:0] != 2'b00)
                            misalign_o <= 1'b1;
                    end else begin
                        pc_o <= pc_o + 32'd4;
                    end
                end
                SHADOW: begin
                    // Branches resolving here are wrong-path and are ignored.
                    pc_o <= pc_o + 32'd4;
                    cnt  <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer and branch-shadow controller for the pipelined core. It owns the fetch PC and advances it by 4 each cycle. It redirects fetch when the writeback stage resolves a taken branch. It then marks the wrong-path instructions that drain into writeback as killed, so their branch and register-write effects are suppressed. It sits between the fetch stage (drives its PC) and the writeback stage (consumes its branch-resolution signals).

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch PC loaded by reset; must be word-aligned.
- `FLUSH_CYCLES`, default 3: number of wrong-path instructions in flight behind a resolved branch (IF..EX depth). Legal range is 1..15.
- `clk` in 1: single core clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `stall_i` in 1: global pipeline freeze; no state advances while high.
- `wbValid_i` in 1: writeback stage holds a valid instruction.
- `branch_i` in 1: writeback instruction is a conditional branch.
- `aluZero_i` in 1: ALU zero flag of the writeback instruction.
- `condZero_i` in 1: branch-polarity bit; the branch is taken when `aluZero_i` equals `condZero_i`.
- `pcBranch_i` in 32: branch target from writeback.
- `pc_o` out 32: current fetch PC (registered).
- `redirect_o` out 1: an accepted taken branch this cycle (combinational pulse).
- `kill_o` out 1: the writeback instruction is wrong-path; writeback must drop its register write and branch (combinational from state).
- `takenCnt_o` out 32: count of accepted taken branches (registered, wraps).
- `misalign_o` out 1: sticky flag, set when a target with nonzero bits [1:0] is accepted.

## Operation
- Branch condition: `taken = wbValid_i & branch_i & ~(aluZero_i ^ condZero_i)`.
- Accept rule: `accept = taken & ~stall_i & (state == RUN)`, and `redirect_o = accept`.
- States: RUN and SHADOW, with a 4-bit shadow counter `cnt`.
- RUN, `stall_i` = 1: hold everything.
- RUN, `accept`:
  - `pc_o <= {pcBranch_i[31:2], 2'b00}`.
  - `cnt <= FLUSH_CYCLES`, go to SHADOW.
  - `takenCnt_o` increments.
  - If `pcBranch_i[1:0] != 0`, set `misalign_o`.
- RUN, otherwise: `pc_o <= pc_o + 4`, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- SHADOW:
  - `kill_o` = 1 in every SHADOW cycle.
  - `taken` is ignored: no redirect, no count, no misalign update.
  - If `stall_i` = 0: `pc_o <= pc_o + 4` and `cnt <= cnt - 1`. When `cnt == 1`, go to RUN.
  - If `stall_i` = 1: `pc_o`, `cnt` and state hold, and `kill_o` stays 1.
- `kill_o` = 0 in RUN.
- Priority: `rst_n` > `stall_i` > accepted branch > sequential increment.
- `stall_i` with `taken` in RUN:
  - The branch is not accepted; the writeback inputs are frozen by the stall.
  - The branch is accepted in the first cycle `stall_i` is low.
- Reset while `rst_n` = 0, on every clock edge, including mid-SHADOW:
  - `pc_o = RESET_PC`, state RUN, `cnt = 0`, `takenCnt_o = 0`, `misalign_o = 0`.
  - `kill_o` and `redirect_o` = 0 from the cycle after the reset edge.

## Timing
- Redirect latency: inputs are sampled at edge t; `pc_o` = target after edge t, which is the first correct-path fetch.
- `kill_o`: high for exactly `FLUSH_CYCLES` non-stalled cycles after the redirect edge, extended one cycle per stalled cycle.
- Back-to-back branches: a second branch reaching writeback in the first RUN cycle after SHADOW is accepted normally, with no dead cycle.
- `takenCnt_o`: wraps 0xFFFF_FFFF to 0 without flagging.
- `misalign_o`: stays high until reset.
- `pc_o` and `takenCnt_o`: update on the clock edge only.
- `redirect_o` and `kill_o`: settle within the cycle from the registered state and the current inputs.

## Test plan
- Reset and sequential fetch: hold `rst_n` = 0 for 2 cycles with `RESET_PC` = 0, then release. Require `pc_o` = 0, 4, 8, 12 on consecutive cycles, `kill_o` = 0 and `takenCnt_o` = 0.
- Taken branch: at `pc_o` = 0x10, drive `wbValid_i` = `branch_i` = 1, `aluZero_i` = `condZero_i` = 1 and `pcBranch_i` = 0x100. Require `redirect_o` = 1 that cycle, `pc_o` = 0x100 next, `kill_o` = 1 for exactly 3 cycles (`pc_o` = 0x100, 0x104, 0x108) and `takenCnt_o` = 1. Also check the not-taken case (`aluZero_i` = 1, `condZero_i` = 0) with the same inputs: require no redirect.
- Branch in the shadow: present a taken branch to 0x200 in the 2nd SHADOW cycle. Require `redirect_o` = 0, `pc_o` continues +4 and `takenCnt_o` is unchanged.
- Stall against branch: hold `stall_i` = 1 for 2 cycles with taken inputs held. Require `pc_o` holds and `redirect_o` = 0. On the first cycle `stall_i` = 0, require redirect, then the target. Separately, assert `stall_i` mid-SHADOW and require `kill_o` extended by the stall length.
- Misaligned target: `pcBranch_i` = 0x102, taken. Require `pc_o` = 0x100 and `misalign_o` = 1, held through later branches until reset clears it.
- Reset mid-SHADOW and wrap: assert `rst_n` = 0 during SHADOW and require `pc_o` = `RESET_PC` and `kill_o` = 0 next cycle. With `RESET_PC` = 0xFFFF_FFF8, require `pc_o` = 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
